mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Main control unit for the multicycle MIPS datapath. It decodes the opcode and funct fields held in the instruction register and steps a Moore state machine through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath select lines, the register, memory and PC write enables, and the 3-bit `aluControl` code for the shared ALU. The block sits between the instruction register and the datapath, and is the only source of `aluControl`.

## Interface
Parameters: none.

- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high; forces state to FETCH
- `opcode`  in  6  instr[31:26] from instruction register
- `funct`  in  6  instr[5:0] from instruction register
- `zero`  in  1  ALU zero flag, combinational from the ALU
- `iOrD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `irWrite`  out  1  instruction register load enable
- `memWrite`  out  1  data memory write enable
- `memtoReg`  out  1  writeback select: 0 = ALUOut, 1 = memory data
- `regDst`  out  1  destination register: 0 = rt, 1 = rd
- `regWrite`  out  1  register file write enable
- `aluSrcA`  out  1  ALU operand A: 0 = PC, 1 = A register
- `aluSrcB`  out  2  ALU operand B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- `pcSrc`  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- `pcEn`  out  1  PC load enable
- `aluControl`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- `illegal`  out  1  one-cycle flag for an unsupported opcode or funct

## Operation
States and transitions (Moore):

- FETCH → DECODE
  - `iOrD`=0, `aluSrcA`=0, `aluSrcB`=01, aluOp=00, `pcSrc`=00, `irWrite`=1, pcWrite=1.
- DECODE, with `aluSrcA`=0, `aluSrcB`=11, aluOp=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXECUTE
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEXEC
  - 000010 (j) → JUMP
  - any other opcode → FETCH with `illegal`=1
- MEMADR (`aluSrcA`=1, `aluSrcB`=10, aluOp=00) → MEMREAD for lw, MEMWRITE for sw.
- MEMREAD (`iOrD`=1) → MEMWB.
- MEMWB (`regDst`=0, `memtoReg`=1, `regWrite`=1) → FETCH.
- MEMWRITE (`iOrD`=1, `memWrite`=1) → FETCH.
- EXECUTE (`aluSrcA`=1, `aluSrcB`=00, aluOp=10):
  - → ALUWB when funct is supported.
  - → FETCH with `illegal`=1 when funct is unsupported; no writeback occurs.
- ALUWB (`regDst`=1, `memtoReg`=0, `regWrite`=1) → FETCH.
- BRANCH (`aluSrcA`=1, `aluSrcB`=00, aluOp=01, `pcSrc`=01, branch=1) → FETCH.
- ADDIEXEC (`aluSrcA`=1, `aluSrcB`=10, aluOp=00) → ADDIWB.
- ADDIWB (`regDst`=0, `memtoReg`=0, `regWrite`=1) → FETCH.
- JUMP (`pcSrc`=10, pcWrite=1) → FETCH.

Output rules:

- Any output not listed for a state is 0.
- `pcEn` = pcWrite | (branch & `zero`).
- `aluControl` is derived from aluOp:
  - aluOp 00 → 010; aluOp 01 → 110.
  - aluOp 10 decodes funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
  - Unsupported funct → 010, with `illegal` raised in EXECUTE only.

## Timing
- Reset:
  - While `reset` is high, state = FETCH.
  - `irWrite`, `pcEn`, `regWrite`, `memWrite` and `illegal` are forced to 0.
  - Select outputs take their FETCH values; `aluControl`=010.
  - The first fetch completes on the first rising edge after `reset` deasserts.
- Reset mid-instruction aborts the instruction immediately and asynchronously; no partial write is issued after assertion.
- State register outputs are registered. `pcEn`, `aluControl` and `illegal` are combinational from state, `zero`, opcode and funct.
- Cycles per instruction, FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- BRANCH samples `zero` in the same cycle; no registering.
- `opcode` and `funct` are stable from the cycle after FETCH until the next FETCH, because `irWrite` is asserted only in FETCH.

## Structure
- Shared package `mips_pkg` holds:
  - state enum, 4-bit encoding, FETCH = 0
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALU control codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  - aluOp codes
- Sub-module `alu_decoder`: combinational mapping of (aluOp, funct) to (`aluControl`, funct_illegal). It is instantiated once; the FSM lives in the top module.

## Test plan
- Reset asserted mid-MEMREAD of lw, then released → state FETCH immediately; no `regWrite` pulse; `irWrite`=`pcEn`=1 in the first cycle after release.
- lw (opcode 100011) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles; `aluControl`=010 in MEMADR; single `regWrite` with `memtoReg`=1 and `regDst`=0.
- R-type with funct 101010 → `aluControl`=111 in EXECUTE; ALUWB has `regWrite`=1 and `regDst`=1; 4 cycles total.
- beq with `zero`=1, then again with `zero`=0 → `aluControl`=110 and `pcSrc`=01 in BRANCH; `pcEn`=1 in the first case and 0 in the second.
- Opcode 111111, then R-type with funct 000000 → `illegal`=1 for exactly one cycle, in DECODE and EXECUTE respectively; `regWrite` and `memWrite` never assert; next state FETCH.
- sw followed by j → `memWrite`=1 for exactly one cycle with `iOrD`=1; JUMP has `pcSrc`=10 and `pcEn`=1; total 7 cycles.

Source files
------------

// File: rtl/mips_multicycle_control_pkg.sv
// ============================================================================
// Module : mips_pkg
// Shared state encodings, opcode/funct constants and ALU codes for the
// multicycle MIPS control unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_FETCH    = 4'd0;
    localparam state_t ST_DECODE   = 4'd1;
    localparam state_t ST_MEMADR   = 4'd2;
    localparam state_t ST_MEMREAD  = 4'd3;
    localparam state_t ST_MEMWB    = 4'd4;
    localparam state_t ST_MEMWRITE = 4'd5;
    localparam state_t ST_EXECUTE  = 4'd6;
    localparam state_t ST_ALUWB    = 4'd7;
    localparam state_t ST_BRANCH   = 4'd8;
    localparam state_t ST_ADDIEXEC = 4'd9;
    localparam state_t ST_ADDIWB   = 4'd10;
    localparam state_t ST_JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic opcode_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_control_if.sv
// ============================================================================
// Module : mips_multicycle_control_if
// Instruction fields and datapath control lines around the control unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       iOrD;
    logic       irWrite;
    logic       memWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic       pcEn;
    logic [2:0] aluControl;
    logic       illegal;

    modport master (
        output opcode, funct, zero,
        input  iOrD, irWrite, memWrite, memtoReg, regDst, regWrite,
               aluSrcA, aluSrcB, pcSrc, pcEn, aluControl, illegal
    );

    modport slave (
        input  opcode, funct, zero,
        output iOrD, irWrite, memWrite, memtoReg, regDst, regWrite,
               aluSrcA, aluSrcB, pcSrc, pcEn, aluControl, illegal
    );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_control_alu_decoder.sv
// ============================================================================
// Module : alu_decoder
// Maps (aluOp, funct) to the 3-bit ALU control code and a funct-illegal flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_control.sv
// ============================================================================
// Module : mips_multicycle_control
// Moore FSM sequencing the multicycle MIPS datapath, one state per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    mips_multicycle_control_if.slave       bus
);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_iord, w_ir_write, w_mem_write, w_memto_reg, w_reg_dst;
    logic       w_reg_write, w_alu_src_a, w_pc_write, w_branch;
    logic [1:0] w_alu_src_b, w_pc_src, w_alu_op;
    logic [2:0] w_alu_control;
    logic       w_funct_illegal;
    logic       w_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_FETCH;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = ST_FETCH;
        case (r_state)
            ST_FETCH: w_next_state = ST_DECODE;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: w_next_state = ST_MEMADR;
                    OP_RTYPE:     w_next_state = ST_EXECUTE;
                    OP_BEQ:       w_next_state = ST_BRANCH;
                    OP_ADDI:      w_next_state = ST_ADDIEXEC;
                    OP_J:         w_next_state = ST_JUMP;
                    default:      w_next_state = ST_FETCH;
                endcase
            end
            ST_MEMADR:   w_next_state = (bus.opcode == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  w_next_state = ST_MEMWB;
            ST_EXECUTE:  w_next_state = w_funct_illegal ? ST_FETCH : ST_ALUWB;
            ST_ADDIEXEC: w_next_state = ST_ADDIWB;
            default:     w_next_state = ST_FETCH;
        endcase
    end

    always_comb begin
        w_iord      = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_memto_reg = 1'b0;
        w_reg_dst   = 1'b0;
        w_reg_write = 1'b0;
        w_alu_src_a = 1'b0;
        w_alu_src_b = 2'b00;
        w_pc_src    = 2'b00;
        w_alu_op    = ALUOP_ADD;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_alu_src_b = 2'b01;
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
            end
            ST_DECODE:   w_alu_src_b = 2'b11;
            ST_MEMADR, ST_ADDIEXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            ST_MEMREAD:  w_iord = 1'b1;
            ST_MEMWB: begin
                w_memto_reg = 1'b1;
                w_reg_write = 1'b1;
            end
            ST_MEMWRITE: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            ST_EXECUTE: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
            end
            ST_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALUOP_SUB;
                w_pc_src    = 2'b01;
                w_branch    = 1'b1;
            end
            ST_ADDIWB:   w_reg_write = 1'b1;
            ST_JUMP: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op        (w_alu_op),
        .funct         (bus.funct),
        .alu_control   (w_alu_control),
        .funct_illegal (w_funct_illegal)
    );

    assign w_illegal = ((r_state == ST_DECODE) && !opcode_supported(bus.opcode)) ||
                       ((r_state == ST_EXECUTE) && w_funct_illegal);

    // Write strobes are gated by reset so an abort never leaks a partial write.
    assign bus.iOrD       = w_iord;
    assign bus.irWrite    = w_ir_write & ~reset;
    assign bus.memWrite   = w_mem_write & ~reset;
    assign bus.memtoReg   = w_memto_reg;
    assign bus.regDst     = w_reg_dst;
    assign bus.regWrite   = w_reg_write & ~reset;
    assign bus.aluSrcA    = w_alu_src_a;
    assign bus.aluSrcB    = w_alu_src_b;
    assign bus.pcSrc      = w_pc_src;
    assign bus.pcEn       = (w_pc_write | (w_branch & bus.zero)) & ~reset;
    assign bus.aluControl = w_alu_control;
    assign bus.illegal    = w_illegal & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
// ============================================================================
// Module : tb_mips_multicycle_control
// Directed cycle-by-cycle checks of the multicycle control outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_control;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {iOrD, irWrite, memWrite, memtoReg, regDst, regWrite, aluSrcA, aluSrcB, pcSrc, pcEn, aluControl, illegal}
    localparam logic [15:0] E_RESET   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,3'b010,1'b0};
    localparam logic [15:0] E_FETCH   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b1,3'b010,1'b0};
    localparam logic [15:0] E_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b0,3'b010,1'b0};
    localparam logic [15:0] E_DEC_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b0,3'b010,1'b1};
    localparam logic [15:0] E_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,3'b010,1'b0};
    localparam logic [15:0] E_MEMREAD = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,3'b010,1'b0};
    localparam logic [15:0] E_MEMWB   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,3'b010,1'b0};
    localparam logic [15:0] E_MEMWR   = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,3'b010,1'b0};
    localparam logic [15:0] E_EX_SLT  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,3'b111,1'b0};
    localparam logic [15:0] E_EX_AND  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,3'b000,1'b0};
    localparam logic [15:0] E_EX_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,3'b010,1'b1};
    localparam logic [15:0] E_ALUWB   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,1'b0,3'b010,1'b0};
    localparam logic [15:0] E_BR_T    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b1,3'b110,1'b0};
    localparam logic [15:0] E_BR_N    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,3'b110,1'b0};
    localparam logic [15:0] E_ADDIWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,3'b010,1'b0};
    localparam logic [15:0] E_JUMP    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b1,3'b010,1'b0};

    function automatic logic [15:0] observed();
        return {bus.iOrD, bus.irWrite, bus.memWrite, bus.memtoReg, bus.regDst,
                bus.regWrite, bus.aluSrcA, bus.aluSrcB, bus.pcSrc, bus.pcEn,
                bus.aluControl, bus.illegal};
    endfunction

    task automatic chk(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        obs = observed();
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [15:0] exp);
        @(negedge clk);
        chk(tag, exp);
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.opcode  = 6'b100011;
        bus.funct   = 6'b000000;
        bus.zero    = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_hold", E_RESET);
        reset = 1'b0;
        #1 chk("lw0_fetch", E_FETCH);
        cyc("lw0_decode", E_DECODE);
        cyc("lw0_memadr", E_MEMADR);
        cyc("lw0_memread", E_MEMREAD);

        // Abort mid-MEMREAD: outputs must drop to reset values without a clock edge.
        #1 reset = 1'b1;
        #1 chk("abort_async", E_RESET);
        cyc("abort_held", E_RESET);
        reset = 1'b0;
        #1 chk("abort_release_fetch", E_FETCH);

        cyc("lw_decode", E_DECODE);
        cyc("lw_memadr", E_MEMADR);
        cyc("lw_memread", E_MEMREAD);
        cyc("lw_memwb", E_MEMWB);
        cyc("lw_next_fetch", E_FETCH);

        bus.opcode = 6'b000000; bus.funct = 6'b101010;
        cyc("slt_decode", E_DECODE);
        cyc("slt_execute", E_EX_SLT);
        cyc("slt_aluwb", E_ALUWB);
        cyc("slt_next_fetch", E_FETCH);

        bus.funct = 6'b100100;
        cyc("and_decode", E_DECODE);
        cyc("and_execute", E_EX_AND);
        cyc("and_aluwb", E_ALUWB);
        cyc("and_next_fetch", E_FETCH);

        bus.opcode = 6'b000100; bus.zero = 1'b1;
        cyc("beq_t_decode", E_DECODE);
        cyc("beq_t_branch", E_BR_T);
        cyc("beq_t_next_fetch", E_FETCH);

        bus.zero = 1'b0;
        cyc("beq_n_decode", E_DECODE);
        cyc("beq_n_branch", E_BR_N);
        bus.zero = 1'b1;
        #1 chk("beq_zero_comb", E_BR_T);
        bus.zero = 1'b0;
        cyc("beq_n_next_fetch", E_FETCH);

        bus.opcode = 6'b111111;
        cyc("illop_decode", E_DEC_ILL);
        cyc("illop_next_fetch", E_FETCH);

        bus.opcode = 6'b000000; bus.funct = 6'b000000;
        cyc("illfn_decode", E_DECODE);
        cyc("illfn_execute", E_EX_ILL);
        cyc("illfn_next_fetch", E_FETCH);

        bus.opcode = 6'b101011;
        cyc("sw_decode", E_DECODE);
        cyc("sw_memadr", E_MEMADR);
        cyc("sw_memwrite", E_MEMWR);
        cyc("sw_next_fetch", E_FETCH);

        bus.opcode = 6'b000010;
        cyc("j_decode", E_DECODE);
        cyc("j_jump", E_JUMP);
        cyc("j_next_fetch", E_FETCH);

        bus.opcode = 6'b001000;
        cyc("addi_decode", E_DECODE);
        cyc("addi_exec", E_MEMADR);
        cyc("addi_wb", E_ADDIWB);
        cyc("addi_next_fetch", E_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
